lcd_char_arbiter: RTL
=====================

// Module: lcd_char_arbiter
// PURPOSE
//  Shares the single lcd_show_char glyph engine among N screen producers (keyboard/menu/
//  status "mode_show" blocks). Each producer issues one-cycle show requests with char
//  fields. The block latches pending requests and grants them round-robin. It forwards
//  the winner's fields to the engine and routes show_char_done back to that producer only.
// PARAMETERS
//  NUM_REQ   2      number of requesters (2..8)
//  TIMEOUT   20'd600000  max BUSY cycles awaiting lcd_show_done before forced release
// PORTS
//  sys_clk        in   1        system clock; all logic on posedge
//  sys_rst        in   1        synchronous, active-high reset
//  init_done      in   1        LCD init finished; no grants while low
//  req_en         in   N        per-requester enable mask (1 = eligible for grant)
//  req_flag       in   N        one-cycle show request pulse per requester
//  req_ascii      in   8N       glyph index (ASCII-32), requester i at [8i+:8]
//  req_x          in   9N       start_x, [9i+:9]
//  req_y          in   9N       start_y, [9i+:9]
//  req_bg         in   16N      background RGB565, [16i+:16]
//  req_fg         in   16N      foreground RGB565, [16i+:16]
//  req_size       in   N        en_size (1 = 16x8, 0 = 12x6)
//  req_done       out  N        one-cycle done pulse to the granted requester
//  lcd_show_flag  out  1        one-cycle start pulse to engine
//  lcd_ascii/lcd_x/lcd_y/lcd_bg/lcd_fg/lcd_en_size  out 8/9/9/16/16/1  latched fields of grantee
//  lcd_show_done  in   1        engine completion pulse
//  grant_id       out  clog2N   index of current/last grantee
//  busy           out  1        high from grant until release
//  timeout_err    out  1        one-cycle pulse on forced release
// BEHAVIOUR
//  Reset: state IDLE, pend=0, rr_ptr=0. All outputs are 0, and the lcd_* fields are 0.
//  pend[i]: set the cycle after req_flag[i]=1; cleared on grant of i. Flags to an already
//   pending requester coalesce. pend is cleared, and flags are ignored, while init_done=0.
//  Requesters hold their fields stable from their flag until their req_done.
//  FSM IDLE -> ISSUE -> BUSY -> IDLE:
//   IDLE: if init_done && |(pend&req_en), winner = first set bit at or after rr_ptr (wraps).
//    At cycle T the winner's fields are sampled into lcd_*, grant_id=winner, pend[w] is cleared,
//    busy=1, and the FSM goes to ISSUE.
//   ISSUE (T+1): lcd_show_flag=1 for exactly this cycle, clear timer -> BUSY.
//   BUSY: lcd_show_done=1 -> next cycle req_done[grant_id]=1, busy=0, rr_ptr=grant_id+1
//    (mod N), -> IDLE. Timer reaches TIMEOUT-1 -> same release + timeout_err=1.
//  Min request-to-flag latency: 2 cycles (flag T0, pend T1, grant T1, lcd_show_flag T2).
//  Back-to-back: one idle cycle between release and next grant. Engine spacing is >=3 cycles.
//  lcd_show_done outside BUSY is ignored. Done and timeout in the same cycle: done wins, no err.
//  A flag from the grantee while BUSY queues a new pend (re-request).
//  req_en dropping during BUSY does not abort. A masked requester keeps its pend.
//  init_done falling during BUSY: the transaction completes normally.
//  lcd_* fields hold their last value after release (engine may sample late).
//  sys_rst mid-transaction: immediate return to reset state; no req_done issued.
// STRUCTURE
//  lcd_arb_pkg: field widths (ASCII_W=8, XY_W=9, COLOR_W=16), FSM state encoding
//   (IDLE/ISSUE/BUSY), timer width.
//  Sub-module lcd_rr_picker: combinational round-robin find-first from rr_ptr over
//   pend&req_en, outputs valid + index. All registers stay in lcd_char_arbiter.
// TESTING
//  1 Single req: N=2, init_done=1, req_flag[0] at T0 with ascii=43,x=48,y=0 -> lcd_show_flag at
//    T2 with those fields; done at T5 -> req_done=2'b01 at T6, busy low at T6.
//  2 Fairness: both requesters flag continuously -> grant_id alternates 0,1,0,1 across
//    8 transactions; no requester is starved.
//  3 Mask/init: req_en=2'b10, flags on both -> only req 1 is served and pend[0] is held.
//    Raise req_en[0] -> req 0 is served next. init_done=0 -> no lcd_show_flag at all.
//  4 Timeout: TIMEOUT=16, withhold lcd_show_done -> timeout_err and req_done[g] pulse on the
//    same cycle, 17 cycles after lcd_show_flag; the next pending request is granted.
//  5 Corner: spurious lcd_show_done in IDLE -> no req_done. Done coincident with timeout ->
//    no timeout_err. sys_rst in BUSY -> busy=0 next cycle, pend=0.
//  6 Integration: two mode_show producers at 108 chars each -> both screens render fully,
//    and the per-requester done count equals the flag count.

Source files
------------

// File: rtl/lcd_arb_pkg.sv
// Shared field widths, timer width and FSM encoding for the LCD character arbiter.
package lcd_arb_pkg;

  localparam int ASCII_W = 8;
  localparam int XY_W    = 9;
  localparam int COLOR_W = 16;
  localparam int TIMER_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin find-first: first set bit of mask at or after ptr, wrapping.
module lcd_rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         mask,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!valid && mask[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Round-robin arbiter sharing one lcd_show_char engine among NUM_REQ screen producers.
module lcd_char_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int                 NUM_REQ = 2,
  parameter logic [TIMER_W-1:0] TIMEOUT = 20'd600000
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         init_done,
  input  logic [NUM_REQ-1:0]           req_en,
  input  logic [NUM_REQ-1:0]           req_flag,
  input  logic [NUM_REQ*ASCII_W-1:0]   req_ascii,
  input  logic [NUM_REQ*XY_W-1:0]      req_x,
  input  logic [NUM_REQ*XY_W-1:0]      req_y,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_bg,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_fg,
  input  logic [NUM_REQ-1:0]           req_size,
  output logic [NUM_REQ-1:0]           req_done,
  output logic                         lcd_show_flag,
  output logic [ASCII_W-1:0]           lcd_ascii,
  output logic [XY_W-1:0]              lcd_x,
  output logic [XY_W-1:0]              lcd_y,
  output logic [COLOR_W-1:0]           lcd_bg,
  output logic [COLOR_W-1:0]           lcd_fg,
  output logic                         lcd_en_size,
  input  logic                         lcd_show_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int                 IDX_W      = $clog2(NUM_REQ);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMEOUT - TIMER_W'(1);

  arb_state_t         state, state_next;
  logic [NUM_REQ-1:0] pend, pend_next;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   rr_ptr, rr_next;
  logic [TIMER_W-1:0] timer;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               do_grant, do_release, do_timeout;

  assign eligible      = pend & req_en;
  assign lcd_show_flag = (state == ST_ISSUE);
  assign rr_next       = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  lcd_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .mask  (eligible),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next state and pending mask; a completion pulse wins over a coincident timeout.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_release = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_done && pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_BUSY;
      ST_BUSY: begin
        if (lcd_show_done) begin
          do_release = 1'b1;
          state_next = ST_IDLE;
        end else if (timer == TIMER_LAST) begin
          do_release = 1'b1;
          do_timeout = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    pend_next = pend;
    if (do_grant) pend_next[pick_idx] = 1'b0;
    pend_next = pend_next | req_flag;
    if (!init_done) pend_next = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      pend        <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      req_done    <= '0;
      timeout_err <= 1'b0;
      lcd_ascii   <= '0;
      lcd_x       <= '0;
      lcd_y       <= '0;
      lcd_bg      <= '0;
      lcd_fg      <= '0;
      lcd_en_size <= 1'b0;
    end else begin
      state       <= state_next;
      pend        <= pend_next;
      req_done    <= '0;
      timeout_err <= 1'b0;

      if (do_grant) begin
        lcd_ascii   <= req_ascii[int'(pick_idx)*ASCII_W +: ASCII_W];
        lcd_x       <= req_x[int'(pick_idx)*XY_W +: XY_W];
        lcd_y       <= req_y[int'(pick_idx)*XY_W +: XY_W];
        lcd_bg      <= req_bg[int'(pick_idx)*COLOR_W +: COLOR_W];
        lcd_fg      <= req_fg[int'(pick_idx)*COLOR_W +: COLOR_W];
        lcd_en_size <= req_size[pick_idx];
        grant_id    <= pick_idx;
        busy        <= 1'b1;
      end

      if (state == ST_ISSUE) timer <= '0;
      else if (state == ST_BUSY) timer <= timer + 1'b1;

      // lcd_* fields are deliberately left holding the last grantee's values.
      if (do_release) begin
        req_done[grant_id] <= 1'b1;
        busy               <= 1'b0;
        rr_ptr             <= rr_next;
        timeout_err        <= do_timeout;
      end
    end
  end

endmodule
